// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: controller state encodings.
// Encoding 2'd3 is unused and recovers to IDLE.
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_adder_fa.sv
// Single-bit full adder cell used as the bit slice of the serial adder.
module fullAdder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic S,
  output logic Cout
);

  assign S    = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: one fullAdder slice, LSB first, carry held in a
// register between cycles. {Cout,S} = A + B + Cin after WIDTH RUN cycles.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] S,
  output logic             Cout
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q;
  logic             ready_q, busy_q, done_q, cout_q, carry_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, s_sh_q, s_q;
  logic [WIDTH-1:0] a_sh_d, b_sh_d, s_sh_d;
  logic [CNT_W-1:0] cnt_q;
  logic             fa_s, fa_cout;

  fullAdder u_fa (
    .A    (a_sh_q[0]),
    .B    (b_sh_q[0]),
    .Cin  (carry_q),
    .S    (fa_s),
    .Cout (fa_cout)
  );

  // Sum bits enter at the MSB so after WIDTH shifts bit 0 sits at the LSB.
  always_comb begin
    a_sh_d = a_sh_q >> 1;
    b_sh_d = b_sh_q >> 1;
    s_sh_d = {fa_s, s_sh_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      s_sh_q  <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sh_q  <= A;
            b_sh_q  <= B;
            carry_q <= Cin;
            s_sh_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_sh_q  <= a_sh_d;
          b_sh_q  <= b_sh_d;
          s_sh_q  <= s_sh_d;
          carry_q <= fa_cout;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BIT) begin
            s_q     <= s_sh_d;
            cout_q  <= fa_cout;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign S     = s_q;
  assign Cout  = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder: an 8-bit instance for handshake and corner
// cases, and a 4-bit instance swept over every operand/carry combination.
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       start8 = 1'b0, cin8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ready8, busy8, done8, cout8;
  logic [7:0] s8;

  logic       start4 = 1'b0, cin4 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic       ready4, busy4, done4, cout4;
  logic [3:0] s4;

  int ncmp = 0;
  int nfail = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  serial_adder #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .start(start8), .A(a8), .B(b8), .Cin(cin8),
    .ready(ready8), .busy(busy8), .done(done8), .S(s8), .Cout(cout8)
  );

  serial_adder #(.WIDTH(4)) u4 (
    .clk(clk), .rst(rst), .start(start4), .A(a4), .B(b4), .Cin(cin4),
    .ready(ready4), .busy(busy4), .done(done4), .S(s4), .Cout(cout4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp)
    else begin
      nfail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Step edges until done8 is seen; lat = edges after the accepting edge.
  task automatic wait_done8(output int lat);
    lat = -1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      if (done8) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_s, input logic exp_c, input string tag);
    int lat;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk({tag, "_busy"}, 32'(busy8), 32'd1);
    wait_done8(lat);
    chk({tag, "_lat"}, 32'(lat), 32'd8);
    chk({tag, "_S"}, 32'(s8), 32'(exp_s));
    chk({tag, "_Cout"}, 32'(cout8), 32'(exp_c));
    chk({tag, "_ready_in_done"}, 32'(ready8), 32'd0);
    tick();
    chk({tag, "_ready_after"}, 32'(ready8), 32'd1);
    chk({tag, "_done_low"}, 32'(done8), 32'd0);
  endtask

  initial begin
    int lat;
    int ndone;
    int prev_cyc;
    logic [4:0] exp5;

    // Reset
    rst = 1'b1;
    tick(); tick();
    @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(ready8), 32'd1);
    chk("rst_busy", 32'(busy8), 32'd0);
    chk("rst_done", 32'(done8), 32'd0);
    chk("rst_S", 32'(s8), 32'd0);
    chk("rst_Cout", 32'(cout8), 32'd0);
    chk("rst_ready4", 32'(ready4), 32'd1);

    // Basic operations
    @(negedge clk);
    run8(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, "add_5A_3C");
    run8(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "add_FF_01");
    run8(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, "add_FF_FF_1");

    // Starts during RUN and DONE are ignored
    a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    tick(); tick();
    a8 = 8'hAA; b8 = 8'h55; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    lat = -1;
    ndone = 0;
    for (int k = 4; k <= 20; k++) begin
      tick();
      if (done8) begin
        lat = k;
        ndone++;
        break;
      end
    end
    chk("ign_lat", 32'(lat), 32'd8);
    chk("ign_S", 32'(s8), 32'h30);
    chk("ign_Cout", 32'(cout8), 32'd0);
    start8 = 1'b1;
    tick();
    start8 = 1'b0;
    chk("ign_ready", 32'(ready8), 32'd1);
    chk("ign_done_low", 32'(done8), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) ndone++;
    end
    chk("ign_single_done", 32'(ndone), 32'd1);
    chk("ign_not_queued", 32'(busy8), 32'd0);
    chk("ign_S_hold", 32'(s8), 32'h30);

    // Reset in the middle of RUN aborts the operation
    a8 = 8'h0F; b8 = 8'h01; cin8 = 1'b0; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    ndone = 0;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done8) ndone++;
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(ready8), 32'd1);
    chk("abort_busy", 32'(busy8), 32'd0);
    chk("abort_S", 32'(s8), 32'd0);
    chk("abort_Cout", 32'(cout8), 32'd0);
    for (int k = 0; k < 12; k++) begin
      tick();
      if (done8) ndone++;
    end
    chk("abort_no_done", 32'(ndone), 32'd0);
    run8(8'h01, 8'h01, 1'b0, 8'h02, 1'b0, "after_abort");

    // 4-bit sweep with start held high
    a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
    prev_cyc = 0;
    for (int i = 0; i < 512; i++) begin
      lat = -1;
      for (int k = 0; k < 12; k++) begin
        tick();
        if (done4) begin
          lat = k;
          break;
        end
      end
      exp5 = 5'(a4) + 5'(b4) + 5'(cin4);
      chk($sformatf("sw4_sum_%0d", i), 32'({cout4, s4}), 32'(exp5));
      if (lat < 0) chk($sformatf("sw4_timeout_%0d", i), 32'd0, 32'd1);
      if (i > 0) chk($sformatf("sw4_spacing_%0d", i), 32'(cyc - prev_cyc), 32'd6);
      prev_cyc = cyc;
      if (i < 511) begin
        a4 = 4'((i + 1) & 15);
        b4 = 4'(((i + 1) >> 4) & 15);
        cin4 = 1'(((i + 1) >> 8) & 1);
      end
    end
    start4 = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
